// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, digit width
// and elaboration-time helpers for sizing and range checking.
package bin_to_bcd_converter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // 10**n as a 64-bit value for the range check.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_converter_dabble_digit.sv
// One BCD digit correction step of the double-dabble algorithm: add 3 when the
// digit is 5 or more, so the following left shift carries into the next digit.
module bin_to_bcd_converter_dabble_digit
  import bin_to_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  // 4-bit add, no carry out; legal inputs never exceed 9 after the shift.
  assign d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: WIDTH-bit binary in, DIGITS packed BCD
// digits out, plus a leading-zero significance mask for display blanking.
module bin_to_bcd_converter
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]         sig_mask
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] MASK_RST = DIGITS'(1);

  // The largest input value must fit in the available decimal digits.
  if (((longint'(1) << WIDTH) - 1) > (pow10(DIGITS) - 1)) begin : g_bad_params
    $error("bin_to_bcd_converter: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  mask_q, mask_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    bin_to_bcd_converter_dabble_digit u_digit (
      .d_in  (scratch_q[DIGIT_W*g +: DIGIT_W]),
      .d_out (scratch_adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Next-state logic: iterate in SHIFT, publish the result when leaving DONE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);

    case (state_q)
      ST_SHIFT: begin
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Result is complete; the registered outputs pick it up on this edge.
        bcd_d     = scratch_q;
        mask_d    = MASK_RST;
        for (int i = 1; i < DIGITS; i++) mask_d[i] = |(scratch_q >> (DIGIT_W * i));
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: ;
    endcase

    // A start in DONE is taken on the same edge the result is published.
    if (accept) begin
      state_d   = ST_SHIFT;
      shift_d   = bin_in;
      scratch_d = '0;
      cnt_d     = CNT_LAST;
    end

    // busy covers the iterations and the final DONE cycle, but is low for the
    // cycle in which done is high, even when a new conversion starts there.
    busy_d = (state_d != ST_IDLE) && (state_q != ST_DONE);
  end

  // State and output registers; reset discards any partial conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      mask_q    <= MASK_RST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      mask_q    <= mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign sig_mask = mask_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  sig_mask;

  int n_cmp;
  int n_fail;
  logic [11:0] exp_bcd;
  logic [2:0]  exp_mask;

  bin_to_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .sig_mask (sig_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Decimal reference built by division, independent of shift-add-3.
  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] model_mask(input int v);
    return {(v >= 100), (v >= 10), 1'b1};
  endfunction

  // One conversion: start accepted at edge k, done expected 9 edges later.
  task automatic run(input logic [7:0] v);
    int cyc;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    cyc    = 0;
    check("busy_after_accept", busy, 1);
    while (!done && cyc < 20) begin
      check("hold_bcd", bcd_out, exp_bcd);
      check("hold_mask", sig_mask, exp_mask);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 9);
    exp_bcd  = model_bcd(v);
    exp_mask = model_mask(v);
    check("bcd", bcd_out, exp_bcd);
    check("mask", sig_mask, exp_mask);
    check("busy_in_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int cyc;
    int ndone;
    n_cmp    = 0;
    n_fail   = 0;
    exp_bcd  = 12'h000;
    exp_mask = 3'b001;
    rst_n    = 1'b0;
    start    = 1'b0;
    bin_in   = 8'd0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 12'h000);
    check("rst_mask", sig_mask, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;

    // 1-2: directed values
    run(8'd0);
    check("zero_bcd", bcd_out, 12'h000);
    check("zero_mask", sig_mask, 3'b001);
    run(8'd255);
    check("255_bcd", bcd_out, 12'h255);
    check("255_mask", sig_mask, 3'b111);
    run(8'd9);
    check("9_bcd", bcd_out, 12'h009);
    check("9_mask", sig_mask, 3'b001);
    run(8'd100);
    check("100_bcd", bcd_out, 12'h100);
    check("100_mask", sig_mask, 3'b111);

    // 3: start re-asserted mid-conversion is ignored
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd42;
    @(negedge clk);
    start  = 1'b0;
    ndone  = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        ndone++;
        check("ign_bcd", bcd_out, 12'h042);
        check("ign_mask", sig_mask, 3'b011);
      end
      start  = (i >= 2 && i <= 4);
      bin_in = 8'd7;
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_single_done", ndone, 1);
    exp_bcd  = 12'h042;
    exp_mask = 3'b011;

    // 4: start held high through done -> back-to-back conversions
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd17;
    @(negedge clk);
    bin_in = 8'd99;
    cyc    = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency1", cyc, 9);
    check("b2b_bcd1", bcd_out, 12'h017);
    check("b2b_mask1", sig_mask, 3'b011);
    check("b2b_busy_low", busy, 0);
    start = 1'b0;
    @(negedge clk);
    cyc = 1;
    check("b2b_busy_back", busy, 1);
    check("b2b_done_low", done, 0);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_gap", cyc, 9);
    check("b2b_bcd2", bcd_out, 12'h099);
    check("b2b_mask2", sig_mask, 3'b011);
    exp_bcd  = 12'h099;
    exp_mask = 3'b011;

    // 5: reset mid-conversion
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bcd", bcd_out, 12'h000);
    check("mid_rst_mask", sig_mask, 3'b001);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_bcd  = 12'h000;
    exp_mask = 3'b001;
    ndone    = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    run(8'd200);
    check("200_bcd", bcd_out, 12'h200);

    // 6: exhaustive sweep against the division model
    for (int v = 0; v < 256; v++) run(8'(v));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
